// File: rtl/regfile_ctrl.sv
// Command sequencer for a four-entry register file: LOAD, MOV and READ with a valid/ready result channel.
// Optional REGCTRL_OP_COUNT_EN adds an 8-bit completed-command counter output op_count.
module regfile_ctrl #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [1:0]                 cmd_dst,
    input  logic [1:0]                 cmd_src,
    input  logic [DATA_W-1:0]          cmd_imm,
    output logic [NUM_REGS-1:0]        write_enable,
    output logic [NUM_REGS-1:0]        read_enable,
    output logic [DATA_W-1:0]          data_in,
    input  logic [NUM_REGS*DATA_W-1:0] rd_data,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [DATA_W-1:0]          result_data,
    output logic                       busy
`ifdef REGCTRL_OP_COUNT_EN
    ,
    output logic [7:0]                 op_count
`endif
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_MOV  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [1:0]            r_op;
    logic [1:0]            r_dst;
    logic [1:0]            r_src;
    logic                  w_accept;
    logic [DATA_W-1:0]     w_rd_slice;
    logic [NUM_REGS-1:0]   r_we;
    logic [NUM_REGS-1:0]   r_re;
    logic [DATA_W-1:0]     r_data_in;
    logic                  r_result_valid;
    logic [DATA_W-1:0]     r_result_data;
    logic                  r_cmd_ready;
    logic                  r_busy;
    logic [NUM_REGS-1:0]   w_we_nxt;
    logic [NUM_REGS-1:0]   w_re_nxt;
    logic [DATA_W-1:0]     w_din_nxt;
    logic [DATA_W-1:0]     w_rdat_nxt;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    assign w_accept   = cmd_valid & r_cmd_ready;
    assign w_rd_slice = rd_data[r_src*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_NOP;
            r_dst   <= '0;
            r_src   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op  <= cmd_op;
                r_dst <= cmd_dst;
                r_src <= cmd_src;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_LOAD:         w_next_state = S_WR;
                        OP_MOV, OP_READ: w_next_state = S_RD;
                        default:         w_next_state = S_IDLE;
                    endcase
                end
            end
            S_RD:    w_next_state = (r_op == OP_MOV) ? S_WR : S_RESP;
            S_WR:    w_next_state = S_IDLE;
            S_RESP:  w_next_state = result_ready ? S_IDLE : S_RESP;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Next-cycle output values; the read slice is sampled while read_enable is live.
    always_comb begin
        w_we_nxt   = '0;
        w_re_nxt   = '0;
        w_din_nxt  = r_data_in;
        w_rdat_nxt = r_result_data;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_op == OP_LOAD) begin
                        w_we_nxt  = onehot(cmd_dst);
                        w_din_nxt = cmd_imm;
                    end else if (cmd_op == OP_MOV || cmd_op == OP_READ) begin
                        w_re_nxt = onehot(cmd_src);
                    end
                end
            end
            S_RD: begin
                if (r_op == OP_MOV) begin
                    w_we_nxt  = onehot(r_dst);
                    w_din_nxt = w_rd_slice;
                end else begin
                    w_rdat_nxt = w_rd_slice;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we           <= '0;
            r_re           <= '0;
            r_data_in      <= '0;
            r_result_valid <= 1'b0;
            r_result_data  <= '0;
            r_cmd_ready    <= 1'b1;
            r_busy         <= 1'b0;
        end else begin
            r_we           <= w_we_nxt;
            r_re           <= w_re_nxt;
            r_data_in      <= w_din_nxt;
            r_result_valid <= (w_next_state == S_RESP);
            r_result_data  <= w_rdat_nxt;
            r_cmd_ready    <= (w_next_state == S_IDLE);
            r_busy         <= (w_next_state != S_IDLE);
        end
    end

    assign write_enable = r_we;
    assign read_enable  = r_re;
    assign data_in      = r_data_in;
    assign result_valid = r_result_valid;
    assign result_data  = r_result_data;
    assign cmd_ready    = r_cmd_ready;
    assign busy         = r_busy;

`ifdef REGCTRL_OP_COUNT_EN
    logic       w_done;
    logic [7:0] r_op_count;

    // Completion: NOP at acceptance, LOAD/MOV leaving WR, READ on result handshake.
    assign w_done = (r_state == S_IDLE && w_accept && cmd_op == OP_NOP) ||
                    (r_state == S_WR) ||
                    (r_state == S_RESP && result_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_count <= '0;
        end else if (w_done) begin
            r_op_count <= r_op_count + 8'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
// Scoreboard bench for regfile_ctrl: driver predicts timed enable/result/ready events, monitor checks them.
module tb_regfile_ctrl;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] MOV  = 2'b10;
    localparam logic [1:0] READ = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op, cmd_dst, cmd_src, cmd_imm;
    logic [3:0] write_enable, read_enable;
    logic [1:0] data_in;
    logic [7:0] rd_data;
    logic       result_valid, result_ready;
    logic [1:0] result_data;
    logic       busy;
`ifdef REGCTRL_OP_COUNT_EN
    logic [7:0] op_count;
    int         n_ops = 0;
`endif

    regfile_ctrl #(.NUM_REGS(4), .DATA_W(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
        .write_enable(write_enable), .read_enable(read_enable), .data_in(data_in),
        .rd_data(rd_data),
        .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
        .busy(busy)
`ifdef REGCTRL_OP_COUNT_EN
        , .op_count(op_count)
`endif
    );

    always #5 clk = ~clk;

    // Physical register file driven by the DUT's enables.
    logic [1:0] rf [4] = '{2'b00, 2'b00, 2'b00, 2'b00};
    assign rd_data = {rf[3], rf[2], rf[1], rf[0]};
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (write_enable[i]) rf[i] <= data_in;
    end

    // Architectural reference model, updated when a command is issued.
    logic [1:0] mdl [4] = '{2'b00, 2'b00, 2'b00, 2'b00};

    typedef struct { int cyc; logic [3:0] en; logic [1:0] data; } ev_t;
    typedef struct { int start; int stop; logic [1:0] data; } res_t;
    typedef struct { int start; int stop; } rdy_t;
    ev_t  q_rd[$];
    ev_t  q_wr[$];
    res_t q_res[$];
    rdy_t q_rdy[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;

    task chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_write_enable", write_enable, 0);
            chk("rst_read_enable", read_enable, 0);
            chk("rst_data_in", data_in, 0);
            chk("rst_result_valid", result_valid, 0);
            chk("rst_result_data", result_data, 0);
            chk("rst_cmd_ready", cmd_ready, 1);
            chk("rst_busy", busy, 0);
            q_rd.delete(); q_wr.delete(); q_res.delete(); q_rdy.delete();
        end else begin
            chk("inv_we_onehot0", $onehot0(write_enable), 1);
            chk("inv_re_onehot0", $onehot0(read_enable), 1);
            chk("inv_no_overlap", (write_enable != 0) && (read_enable != 0), 0);
            chk("busy_vs_ready", busy, !cmd_ready);

            if (read_enable != 0) begin
                if (q_rd.size() == 0) chk("unexpected_read", read_enable, 0);
                else begin
                    chk("read_cycle", cyc, q_rd[0].cyc);
                    chk("read_enable", read_enable, q_rd[0].en);
                    void'(q_rd.pop_front());
                end
            end else if (q_rd.size() != 0 && q_rd[0].cyc <= cyc) begin
                chk("missing_read", read_enable, q_rd[0].en);
                void'(q_rd.pop_front());
            end

            if (write_enable != 0) begin
                if (q_wr.size() == 0) chk("unexpected_write", write_enable, 0);
                else begin
                    chk("write_cycle", cyc, q_wr[0].cyc);
                    chk("write_enable", write_enable, q_wr[0].en);
                    chk("write_data", data_in, q_wr[0].data);
                    void'(q_wr.pop_front());
                end
            end else if (q_wr.size() != 0 && q_wr[0].cyc <= cyc) begin
                chk("missing_write", write_enable, q_wr[0].en);
                void'(q_wr.pop_front());
            end

            if (result_valid) begin
                if (q_res.size() == 0) chk("unexpected_result", result_valid, 0);
                else begin
                    chk("result_window", (cyc >= q_res[0].start) && (cyc <= q_res[0].stop), 1);
                    chk("result_data", result_data, q_res[0].data);
                    if (result_ready) begin
                        chk("result_hs_cycle", cyc, q_res[0].stop);
                        void'(q_res.pop_front());
                    end
                end
            end else if (q_res.size() != 0 && cyc >= q_res[0].start) begin
                chk("missing_result", result_valid, 1);
                void'(q_res.pop_front());
            end

            if (q_rdy.size() == 0 || cyc < q_rdy[0].start) chk("ready_idle", cmd_ready, 1);
            else if (cyc < q_rdy[0].stop) chk("ready_busy", cmd_ready, 0);
            else begin
                chk("ready_return", cmd_ready, 1);
                void'(q_rdy.pop_front());
            end
        end

        if (done) begin
            chk("queues_drained", q_rd.size() + q_wr.size() + q_res.size() + q_rdy.size(), 0);
`ifdef REGCTRL_OP_COUNT_EN
            chk("op_count", op_count, n_ops % 256);
`endif
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    // Called at posedge+1; returns at posedge+1 once the command's handshakes are done.
    task automatic issue(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                         input logic [1:0] imm, input int d);
        int c;
        int guard;
        cmd_valid = 1'b1;
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
        guard = 0;
        while (!cmd_ready) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 50) begin
                $display("FAIL cmd_ready_timeout: cmd_ready got 0 required 1");
                $fatal(1);
            end
        end
        c = cyc + 1;
        case (op)
            NOP: q_rdy.push_back('{start: c, stop: c});
            LOAD: begin
                q_wr.push_back('{cyc: c, en: 4'b0001 << dst, data: imm});
                q_rdy.push_back('{start: c, stop: c + 1});
                mdl[dst] = imm;
            end
            MOV: begin
                q_rd.push_back('{cyc: c, en: 4'b0001 << src, data: 2'b00});
                q_wr.push_back('{cyc: c + 1, en: 4'b0001 << dst, data: mdl[src]});
                q_rdy.push_back('{start: c, stop: c + 2});
                mdl[dst] = mdl[src];
            end
            default: begin
                q_rd.push_back('{cyc: c, en: 4'b0001 << src, data: 2'b00});
                q_res.push_back('{start: c + 1, stop: c + 1 + d, data: mdl[src]});
                q_rdy.push_back('{start: c, stop: c + 2 + d});
            end
        endcase
`ifdef REGCTRL_OP_COUNT_EN
        n_ops++;
`endif
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op  = 2'($urandom_range(0, 3));
        cmd_dst = 2'($urandom_range(0, 3));
        cmd_src = 2'($urandom_range(0, 3));
        cmd_imm = 2'($urandom_range(0, 3));
        if (op == READ) begin
            while (cyc < c + 1 + d) begin @(posedge clk); #1; end
            result_ready = 1'b1;
            @(posedge clk); #1;
            result_ready = 1'b0;
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = NOP; cmd_dst = 2'd0; cmd_src = 2'd0; cmd_imm = 2'd0;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        issue(LOAD, 2'd2, 2'd0, 2'b11, 0);
        issue(LOAD, 2'd0, 2'd0, 2'b01, 0);
        issue(MOV,  2'd3, 2'd0, 2'b00, 0);
        issue(LOAD, 2'd1, 2'd0, 2'b10, 0);
        issue(READ, 2'd0, 2'd1, 2'b00, 3);
        issue(MOV,  2'd1, 2'd1, 2'b00, 0);
        issue(NOP,  2'd0, 2'd0, 2'b00, 0);
        issue(READ, 2'd0, 2'd3, 2'b00, 0);

        // Reset lands in the RD cycle of a MOV; the write must never happen.
        cmd_valid = 1'b1; cmd_op = MOV; cmd_src = 2'd2; cmd_dst = 2'd0; cmd_imm = 2'd0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2 reset = 1'b1;
`ifdef REGCTRL_OP_COUNT_EN
        n_ops = 0;
`endif
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 320; i++) begin
            issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end

        repeat (6) begin @(posedge clk); #1; end
        done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
